controle_rodadas: RTL and testbench
===================================

Name: controle_rodadas

Overview:
- Moore-FSM control unit for the memory-game datapath (sequence memory, address counter E, limit counter L, play register, comparator).
- Sequences each round:
  - show the first stored play;
  - the player repeats the sequence up to the current limit;
  - the player adds one new play to memory;
  - the limit increments.
- Owns the display/timeout timer and the mode/timeout configuration latch.
- Reports win, loss and timeout to the top level.

Parameters:
- T_EXIBE, 2000, cycles the initial play is shown (2 s at 1 kHz).
- T_TIMEOUT, 5000, cycles allowed per play before timeout (5 s at 1 kHz).
- LIM_DEMO, 3, final limit value in demo mode (4 rounds).
- LIM_NORMAL, 15, final limit value in normal mode (16 rounds).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; returns FSM to INICIAL.
- jogar  in  1  start request; a level is accepted.
- configuracao  in  2  [0]=demo mode, [1]=timeout enable.
- jogada  in  1  one-cycle pulse from the button edge detector.
- igual  in  1  comparator result (play register == memory word).
- endereco  in  4  counter E value.
- limite  in  4  counter L value.
- zeraE, contaE, zeraL, contaL  out  1 each  counter controls.
- registraR  out  1  load play register.
- escreve  out  1  memory write enable.
- mostra_leds  out  1  drive leds from memory output.
- pronto, ganhou, perdeu, timeout  out  1 each  status outputs.
- db_estado  out  5  current state code.

Behaviour:
- Reset (async):
  - state=INICIAL, timer=0, cfg latch=00.
  - All outputs 0, except zeraE=zeraL=1 in INICIAL.
- All outputs are decoded from the state register only.
  - A transition decided at edge n is visible after edge n.
  - Example: jogada high in cycle n gives registraR high in cycle n+1.
- Internal comparisons:
  - fimE = (endereco==limite).
  - fimL = (limite == (cfg[0] ? LIM_DEMO : LIM_NORMAL)).
- Timer:
  - Cleared on every state change.
  - Increments only in EXIBE, ESPERA, ESPERA_NOVA.
  - Saturates at its maximum.
- States (code), outputs and transitions:
  - INICIAL(0): zeraE, zeraL. jogar→PREPARA.
  - PREPARA(1): zeraE, zeraL; cfg latched from configuracao. →EXIBE.
  - EXIBE(2): mostra_leds. timer==T_EXIBE-1→ESPERA.
  - ESPERA(3): waits for a play.
    - jogada→REGISTRA.
    - Else if cfg[1] and timer==T_TIMEOUT-1→FIM_TIMEOUT.
  - REGISTRA(4): registraR. →COMPARA.
  - COMPARA(5): resolves the play.
    - !igual→FIM_ERRO.
    - igual&!fimE→PROXIMO.
    - igual&fimE→VERIFICA.
  - PROXIMO(6): contaE. →ESPERA.
  - VERIFICA(7): fimL→FIM_ACERTO; else→PREP_NOVA.
  - PREP_NOVA(8): contaE, so address = limite+1. →ESPERA_NOVA.
  - ESPERA_NOVA(9): same jogada/timeout rules as ESPERA; jogada→REG_NOVA.
  - REG_NOVA(10): registraR. →ESCREVE.
  - ESCREVE(11): escreve. →AUMENTA.
  - AUMENTA(12): contaL, zeraE. →ESPERA.
  - FIM_ACERTO(13): pronto=1, ganhou=1.
  - FIM_ERRO(14): pronto=1, perdeu=1.
  - FIM_TIMEOUT(15): pronto=1, timeout=1.
  - Every FIM_* state holds until jogar→PREPARA (new game without reset).
- Boundary rules:
  - jogada and timeout in the same cycle: jogada wins.
  - jogada outside ESPERA/ESPERA_NOVA is ignored.
  - jogar outside INICIAL/FIM_* is ignored.
  - configuracao changes after PREPARA have no effect until the next game.
  - Reset mid-game aborts immediately: no escreve/contaL glitch and outputs clear asynchronously.
  - cfg[1]=0: the timer never forces a timeout, however long the wait.
  - Unused codes 16–31 →INICIAL.

Decomposition:
- Package jogo_pkg holds:
  - the 5-bit state localparams with the codes above;
  - LIM_DEMO, LIM_NORMAL and the default T_EXIBE/T_TIMEOUT.
- One sub-module, temporizador_jogo:
  - clear/enable counter, width $clog2(max(T_EXIBE,T_TIMEOUT)+1);
  - outputs fim_exibe and fim_timeout.
- The FSM, configuration latch and fimE/fimL comparisons stay in controle_rodadas.

Test Plan:
- Reset for 2 cycles then release → db_estado=0, zeraE=zeraL=1, all status outputs 0. Assert reset in ESPERA → db_estado=0 in the same cycle.
- Demo win: configuracao=01, jogar pulse; EXIBE lasts exactly 2000 cycles. Drive the datapath model with correct plays for rounds limite=0..3, each round adding one play → exactly 3 escreve pulses and 3 contaL pulses; ends FIM_ACERTO with ganhou=1, pronto=1, perdeu=0, timeout=0.
- Wrong play: round limite=1, second play with igual=0 → FIM_ERRO, perdeu=1; then jogar → PREPARA and a new game starts without reset.
- Timeout: configuracao=11, no jogada in ESPERA → FIM_TIMEOUT exactly 5000 cycles after ESPERA entry, timeout=1. Same stimulus with configuracao=01 → stays in ESPERA after 10000 cycles.
- Race and latch: jogada on the timeout cycle → REGISTRA, no timeout. Flip configuracao mid-game → fimL threshold is unchanged.
- Latency: jogada pulse at cycle n → registraR=1 only in cycle n+1. escreve is asserted only in ESCREVE, with endereco==limite+1.

Source files
------------

// File: rtl/jogo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jogo_pkg
// Purpose  : State codes, game limits, timer defaults and the output decoder
//            shared by the memory-game round controller.
// Revision : 1.0 - initial release
// ============================================================================
package jogo_pkg;

    localparam int LIM_DEMO         = 3;
    localparam int LIM_NORMAL       = 15;
    localparam int T_EXIBE_PADRAO   = 2000;
    localparam int T_TIMEOUT_PADRAO = 5000;

    localparam logic [4:0] ST_INICIAL     = 5'd0;
    localparam logic [4:0] ST_PREPARA     = 5'd1;
    localparam logic [4:0] ST_EXIBE       = 5'd2;
    localparam logic [4:0] ST_ESPERA      = 5'd3;
    localparam logic [4:0] ST_REGISTRA    = 5'd4;
    localparam logic [4:0] ST_COMPARA     = 5'd5;
    localparam logic [4:0] ST_PROXIMO     = 5'd6;
    localparam logic [4:0] ST_VERIFICA    = 5'd7;
    localparam logic [4:0] ST_PREP_NOVA   = 5'd8;
    localparam logic [4:0] ST_ESPERA_NOVA = 5'd9;
    localparam logic [4:0] ST_REG_NOVA    = 5'd10;
    localparam logic [4:0] ST_ESCREVE     = 5'd11;
    localparam logic [4:0] ST_AUMENTA     = 5'd12;
    localparam logic [4:0] ST_FIM_ACERTO  = 5'd13;
    localparam logic [4:0] ST_FIM_ERRO    = 5'd14;
    localparam logic [4:0] ST_FIM_TIMEOUT = 5'd15;

    typedef enum logic [4:0] {
        INICIAL     = ST_INICIAL,
        PREPARA     = ST_PREPARA,
        EXIBE       = ST_EXIBE,
        ESPERA      = ST_ESPERA,
        REGISTRA    = ST_REGISTRA,
        COMPARA     = ST_COMPARA,
        PROXIMO     = ST_PROXIMO,
        VERIFICA    = ST_VERIFICA,
        PREP_NOVA   = ST_PREP_NOVA,
        ESPERA_NOVA = ST_ESPERA_NOVA,
        REG_NOVA    = ST_REG_NOVA,
        ESCREVE     = ST_ESCREVE,
        AUMENTA     = ST_AUMENTA,
        FIM_ACERTO  = ST_FIM_ACERTO,
        FIM_ERRO    = ST_FIM_ERRO,
        FIM_TIMEOUT = ST_FIM_TIMEOUT
    } estado_t;

    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_l;
        logic conta_l;
        logic registra_r;
        logic escreve;
        logic mostra_leds;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic timeout;
    } saidas_t;

    // Moore decode: every control/status output is a pure function of the state
    function automatic saidas_t decodifica(input estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            INICIAL, PREPARA:     begin s.zera_e = 1'b1; s.zera_l = 1'b1; end
            EXIBE:                s.mostra_leds = 1'b1;
            REGISTRA, REG_NOVA:   s.registra_r = 1'b1;
            PROXIMO, PREP_NOVA:   s.conta_e = 1'b1;
            ESCREVE:              s.escreve = 1'b1;
            AUMENTA:              begin s.conta_l = 1'b1; s.zera_e = 1'b1; end
            FIM_ACERTO:           begin s.pronto = 1'b1; s.ganhou = 1'b1; end
            FIM_ERRO:             begin s.pronto = 1'b1; s.perdeu = 1'b1; end
            FIM_TIMEOUT:          begin s.pronto = 1'b1; s.timeout = 1'b1; end
            default:              s = '0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/controle_rodadas_if.sv
`default_nettype none
// ============================================================================
// Module   : controle_rodadas_if
// Purpose  : Bundle between the round controller and the game datapath.
//            master = datapath/top side, slave = controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface controle_rodadas_if;
    logic       jogar;
    logic [1:0] configuracao;
    logic       jogada;
    logic       igual;
    logic [3:0] endereco;
    logic [3:0] limite;
    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       registraR;
    logic       escreve;
    logic       mostra_leds;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic [4:0] db_estado;

    modport master (
        output jogar, configuracao, jogada, igual, endereco, limite,
        input  zeraE, contaE, zeraL, contaL, registraR, escreve, mostra_leds,
        input  pronto, ganhou, perdeu, timeout, db_estado
    );

    modport slave (
        input  jogar, configuracao, jogada, igual, endereco, limite,
        output zeraE, contaE, zeraL, contaL, registraR, escreve, mostra_leds,
        output pronto, ganhou, perdeu, timeout, db_estado
    );
endinterface
`default_nettype wire

// File: rtl/temporizador_jogo.sv
`default_nettype none
// ============================================================================
// Module   : temporizador_jogo
// Purpose  : Saturating display/timeout timer with synchronous clear and
//            count enable; flags the last cycle of each interval.
// Revision : 1.0 - initial release
// ============================================================================
module temporizador_jogo #(
    parameter int T_EXIBE   = 2000,
    parameter int T_TIMEOUT = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic conta,
    output logic fim_exibe,
    output logic fim_timeout
);
    localparam int MAIOR   = (T_EXIBE > T_TIMEOUT) ? T_EXIBE : T_TIMEOUT;
    localparam int LARGURA = $clog2(MAIOR + 1);

    logic [LARGURA-1:0] contagem;

    // Clear wins over count; the counter parks at all-ones instead of wrapping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (limpa) begin
            contagem <= '0;
        end else if (conta && (contagem != {LARGURA{1'b1}})) begin
            contagem <= contagem + LARGURA'(1);
        end
    end

    assign fim_exibe   = (contagem == LARGURA'(T_EXIBE - 1));
    assign fim_timeout = (contagem == LARGURA'(T_TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/controle_rodadas.sv
`default_nettype none
// ============================================================================
// Module   : controle_rodadas
// Purpose  : Moore round controller for the memory game: shows the first
//            play, checks the repeated sequence, stores one new play per
//            round and reports win / loss / timeout.
// Revision : 1.0 - initial release
// ============================================================================
module controle_rodadas
    import jogo_pkg::*;
#(
    parameter int T_EXIBE   = T_EXIBE_PADRAO,
    parameter int T_TIMEOUT = T_TIMEOUT_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    controle_rodadas_if.slave bus
);
    estado_t    estado;
    estado_t    proximo;
    saidas_t    saidas;
    logic [1:0] cfg;
    logic       fim_e;
    logic       fim_l;
    logic       fim_exibe;
    logic       fim_timeout;
    logic       limpa_tempo;
    logic       conta_tempo;

    assign fim_e = (bus.endereco == bus.limite);
    assign fim_l = (bus.limite == (cfg[0] ? 4'(LIM_DEMO) : 4'(LIM_NORMAL)));

    // Timer restarts on every state change so each wait is measured from entry
    assign limpa_tempo = (proximo != estado);
    assign conta_tempo = (estado == EXIBE) || (estado == ESPERA) || (estado == ESPERA_NOVA);

    temporizador_jogo #(
        .T_EXIBE   (T_EXIBE),
        .T_TIMEOUT (T_TIMEOUT)
    ) u_temporizador (
        .clock       (clock),
        .reset       (reset),
        .limpa       (limpa_tempo),
        .conta       (conta_tempo),
        .fim_exibe   (fim_exibe),
        .fim_timeout (fim_timeout)
    );

    // Next-state rules; a play always beats a simultaneous timeout
    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:     if (bus.jogar) proximo = PREPARA;
            PREPARA:     proximo = EXIBE;
            EXIBE:       if (fim_exibe) proximo = ESPERA;
            ESPERA: begin
                if (bus.jogada)                proximo = REGISTRA;
                else if (cfg[1] && fim_timeout) proximo = FIM_TIMEOUT;
            end
            REGISTRA:    proximo = COMPARA;
            COMPARA: begin
                if (!bus.igual) proximo = FIM_ERRO;
                else if (!fim_e) proximo = PROXIMO;
                else             proximo = VERIFICA;
            end
            PROXIMO:     proximo = ESPERA;
            VERIFICA:    proximo = fim_l ? FIM_ACERTO : PREP_NOVA;
            PREP_NOVA:   proximo = ESPERA_NOVA;
            ESPERA_NOVA: begin
                if (bus.jogada)                proximo = REG_NOVA;
                else if (cfg[1] && fim_timeout) proximo = FIM_TIMEOUT;
            end
            REG_NOVA:    proximo = ESCREVE;
            ESCREVE:     proximo = AUMENTA;
            AUMENTA:     proximo = ESPERA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (bus.jogar) proximo = PREPARA;
            default:     proximo = INICIAL;
        endcase
    end

    // State, registered outputs and the per-game configuration latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
            saidas <= decodifica(INICIAL);
            cfg    <= 2'b00;
        end else begin
            estado <= proximo;
            saidas <= decodifica(proximo);
            if (estado == PREPARA) begin
                cfg <= bus.configuracao;
            end
        end
    end

    assign bus.zeraE       = saidas.zera_e;
    assign bus.contaE      = saidas.conta_e;
    assign bus.zeraL       = saidas.zera_l;
    assign bus.contaL      = saidas.conta_l;
    assign bus.registraR   = saidas.registra_r;
    assign bus.escreve     = saidas.escreve;
    assign bus.mostra_leds = saidas.mostra_leds;
    assign bus.pronto      = saidas.pronto;
    assign bus.ganhou      = saidas.ganhou;
    assign bus.perdeu      = saidas.perdeu;
    assign bus.timeout     = saidas.timeout;
    assign bus.db_estado   = estado;

endmodule
`default_nettype wire

// File: tb/tb_controle_rodadas.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_rodadas
// Purpose  : Self-checking bench for controle_rodadas with a datapath model
//            (counters, sequence memory, play register) and a game-level
//            expectation model of the stored sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_rodadas;
    import jogo_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    controle_rodadas_if bus ();

    controle_rodadas dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ---------------- datapath model ----------------
    logic [3:0] mem [16] = '{default: 4'd0};
    logic [3:0] end_e = 4'd0;
    logic [3:0] lim_l = 4'd0;
    logic [3:0] reg_r = 4'd0;
    logic [3:0] botoes = 4'd0;
    logic       carga = 1'b0;
    logic [3:0] carga_valor = 4'd0;
    int         n_escreve = 0;
    int         n_contal = 0;
    int         n_end_errado = 0;
    logic [3:0] seq [$];

    assign bus.endereco = end_e;
    assign bus.limite   = lim_l;
    assign bus.igual    = (reg_r == mem[end_e]);

    // Counters E/L, play register and memory react to the controller outputs
    always @(posedge clock) begin
        if (bus.zeraE)       end_e <= 4'd0;
        else if (bus.contaE) end_e <= end_e + 4'd1;
        if (bus.zeraL)       lim_l <= 4'd0;
        else if (bus.contaL) lim_l <= lim_l + 4'd1;
        if (bus.registraR)   reg_r <= botoes;
        if (carga)           mem[0] <= carga_valor;
        else if (bus.escreve) mem[end_e] <= reg_r;
    end

    // Event counters sampled mid-cycle
    always @(negedge clock) begin
        if (bus.escreve === 1'b1) begin
            n_escreve <= n_escreve + 1;
            if (bus.endereco !== bus.limite + 4'd1) n_end_errado <= n_end_errado + 1;
        end
        if (bus.contaL === 1'b1) n_contal <= n_contal + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reiniciar();
        bus.jogar = 1'b0;
        bus.jogada = 1'b0;
        bus.configuracao = 2'b00;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic espera_estado(input logic [4:0] alvo, input int limite_ciclos);
        int n = 0;
        while (bus.db_estado !== alvo && n < limite_ciclos) begin
            tick();
            n++;
        end
    endtask

    // Starts a game and measures how long EXIBE lasts; optional noise in EXIBE
    task automatic inicia(input logic [1:0] cfg, input bit perturba,
                          output logic [4:0] st_prepara, output int dur, output logic leds);
        bus.configuracao = cfg;
        carga_valor = 4'($urandom);
        carga = 1'b1;
        bus.jogar = 1'b1;
        seq = {};
        seq.push_back(carga_valor);
        tick();
        carga = 1'b0;
        bus.jogar = 1'b0;
        st_prepara = bus.db_estado;
        tick();
        leds = bus.mostra_leds;
        dur = 0;
        while (bus.db_estado === 5'd2 && dur < 3000) begin
            if (perturba && dur == 100) begin bus.jogada = 1'b1; bus.jogar = 1'b1; end
            if (dur == 101) begin bus.jogada = 1'b0; bus.jogar = 1'b0; end
            dur++;
            tick();
        end
        bus.jogada = 1'b0;
        bus.jogar = 1'b0;
    endtask

    // One play: waits for a waiting state, pulses jogada, observes registraR
    task automatic faz_jogada(input logic [3:0] v, output bit chegou, output bit lat_ok);
        int n = 0;
        chegou = 1'b0;
        lat_ok = 1'b0;
        while (!(bus.db_estado === 5'd3 || bus.db_estado === 5'd9) && n < 40) begin
            tick();
            n++;
        end
        if (bus.db_estado === 5'd3 || bus.db_estado === 5'd9) begin
            chegou = 1'b1;
            repeat ($urandom_range(0, 2)) tick();
            botoes = v;
            bus.jogada = 1'b1;
            lat_ok = (bus.registraR === 1'b0);
            tick();
            bus.jogada = 1'b0;
            lat_ok = lat_ok && (bus.registraR === 1'b1);
            tick();
            lat_ok = lat_ok && (bus.registraR === 1'b0);
        end
    endtask

    // Round r: repeat seq[0..r] (optionally wrong at pos_erro), then maybe add a play
    task automatic rodada(input int r, input bit adiciona, input int pos_erro, inout int falhas);
        bit ch, lo;
        logic [3:0] v;
        for (int i = 0; i <= r; i++) begin
            v = (i == pos_erro) ? (seq[i] ^ 4'($urandom_range(1, 15))) : seq[i];
            faz_jogada(v, ch, lo);
            if (!ch || !lo) falhas++;
            if (i == pos_erro) return;
        end
        if (adiciona) begin
            v = 4'($urandom);
            faz_jogada(v, ch, lo);
            if (!ch || !lo) falhas++;
            seq.push_back(v);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reiniciar();
        checks++;
        if (bus.db_estado !== 5'd0) begin failures++; $display("FAIL reset_estado: got %0d expected 0", bus.db_estado); end
        checks++;
        if ({bus.zeraE, bus.zeraL} !== 2'b11) begin failures++; $display("FAIL reset_zera: got %b expected 11", {bus.zeraE, bus.zeraL}); end
        checks++;
        if ({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout} !== 4'b0000) begin
            failures++; $display("FAIL reset_status: got %b expected 0000", {bus.pronto, bus.ganhou, bus.perdeu, bus.timeout});
        end
        checks++;
        if ({bus.contaE, bus.contaL, bus.registraR, bus.escreve, bus.mostra_leds} !== 5'b0) begin
            failures++; $display("FAIL reset_controle: got %b expected 00000",
                {bus.contaE, bus.contaL, bus.registraR, bus.escreve, bus.mostra_leds});
        end
    endtask

    task automatic test_vitoria_demo();
        logic [4:0] stp; int dur; logic leds; int falhas = 0;
        int b_e, b_l, b_x;
        reiniciar();
        b_e = n_escreve; b_l = n_contal; b_x = n_end_errado;
        inicia(2'b01, 1'b1, stp, dur, leds);
        checks++;
        if (stp !== 5'd1) begin failures++; $display("FAIL vit_prepara: got %0d expected 1", stp); end
        checks++;
        if (dur != 2000) begin failures++; $display("FAIL vit_exibe_ciclos: got %0d expected 2000", dur); end
        checks++;
        if (leds !== 1'b1) begin failures++; $display("FAIL vit_mostra_leds: got %b expected 1", leds); end
        for (int r = 0; r <= LIM_DEMO; r++) rodada(r, (r < LIM_DEMO), -1, falhas);
        espera_estado(5'd13, 10);
        checks++;
        if (falhas != 0) begin failures++; $display("FAIL vit_jogadas: got %0d bad plays expected 0", falhas); end
        checks++;
        if (bus.db_estado !== 5'd13) begin failures++; $display("FAIL vit_estado: got %0d expected 13", bus.db_estado); end
        checks++;
        if ({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout} !== 4'b1100) begin
            failures++; $display("FAIL vit_status: got %b expected 1100", {bus.pronto, bus.ganhou, bus.perdeu, bus.timeout});
        end
        checks++;
        if (n_escreve - b_e != LIM_DEMO) begin failures++; $display("FAIL vit_escreve: got %0d expected %0d", n_escreve - b_e, LIM_DEMO); end
        checks++;
        if (n_contal - b_l != LIM_DEMO) begin failures++; $display("FAIL vit_contaL: got %0d expected %0d", n_contal - b_l, LIM_DEMO); end
        checks++;
        if (n_end_errado != b_x) begin failures++; $display("FAIL vit_end_escrita: got %0d writes off limite+1 expected 0", n_end_errado - b_x); end
        for (int i = 0; i <= LIM_DEMO; i++) begin
            checks++;
            if (mem[i] !== seq[i]) begin failures++; $display("FAIL vit_memoria[%0d]: got %h expected %h", i, mem[i], seq[i]); end
        end
    endtask

    task automatic test_erro();
        logic [4:0] stp; int dur; logic leds; int falhas = 0; int b_e;
        reiniciar();
        b_e = n_escreve;
        inicia(2'b01, 1'b0, stp, dur, leds);
        rodada(0, 1'b1, -1, falhas);
        rodada(1, 1'b0, 1, falhas);
        espera_estado(5'd14, 10);
        checks++;
        if (bus.db_estado !== 5'd14) begin failures++; $display("FAIL erro_estado: got %0d expected 14", bus.db_estado); end
        checks++;
        if ({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout} !== 4'b1010) begin
            failures++; $display("FAIL erro_status: got %b expected 1010", {bus.pronto, bus.ganhou, bus.perdeu, bus.timeout});
        end
        checks++;
        if (n_escreve - b_e != 1) begin failures++; $display("FAIL erro_escreve: got %0d expected 1", n_escreve - b_e); end
        inicia(2'b01, 1'b0, stp, dur, leds);
        checks++;
        if (stp !== 5'd1) begin failures++; $display("FAIL erro_novo_jogo: got %0d expected 1", stp); end
        checks++;
        if (dur != 2000) begin failures++; $display("FAIL erro_novo_exibe: got %0d expected 2000", dur); end
        rodada(0, 1'b1, -1, falhas);
        checks++;
        if (falhas != 0) begin failures++; $display("FAIL erro_jogadas: got %0d bad plays expected 0", falhas); end
    endtask

    task automatic test_timeout();
        logic [4:0] stp; int dur; logic leds; int n = 0;
        reiniciar();
        inicia(2'b11, 1'b0, stp, dur, leds);
        while (bus.db_estado === 5'd3 && n < 6000) begin n++; tick(); end
        checks++;
        if (n != 5000) begin failures++; $display("FAIL timeout_ciclos: got %0d expected 5000", n); end
        checks++;
        if (bus.db_estado !== 5'd15) begin failures++; $display("FAIL timeout_estado: got %0d expected 15", bus.db_estado); end
        checks++;
        if ({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout} !== 4'b1001) begin
            failures++; $display("FAIL timeout_status: got %b expected 1001", {bus.pronto, bus.ganhou, bus.perdeu, bus.timeout});
        end
    endtask

    task automatic test_sem_timeout();
        logic [4:0] stp; int dur; logic leds;
        reiniciar();
        inicia(2'b01, 1'b0, stp, dur, leds);
        repeat (10000) tick();
        checks++;
        if (bus.db_estado !== 5'd3 || bus.timeout !== 1'b0) begin
            failures++; $display("FAIL sem_timeout: got estado=%0d timeout=%b expected estado=3 timeout=0", bus.db_estado, bus.timeout);
        end
    endtask

    task automatic test_corrida();
        logic [4:0] stp; int dur; logic leds;
        reiniciar();
        inicia(2'b11, 1'b0, stp, dur, leds);
        repeat (4999) tick();
        checks++;
        if (bus.db_estado !== 5'd3) begin failures++; $display("FAIL corrida_pre: got %0d expected 3", bus.db_estado); end
        botoes = seq[0];
        bus.jogada = 1'b1;
        tick();
        bus.jogada = 1'b0;
        checks++;
        if (bus.db_estado !== 5'd4 || bus.timeout !== 1'b0) begin
            failures++; $display("FAIL corrida_jogada: got estado=%0d timeout=%b expected estado=4 timeout=0", bus.db_estado, bus.timeout);
        end
        espera_estado(5'd9, 10);
        checks++;
        if (bus.db_estado !== 5'd9) begin failures++; $display("FAIL corrida_aceita: got %0d expected 9", bus.db_estado); end
    endtask

    task automatic test_config_latch();
        logic [4:0] stp; int dur; logic leds; int falhas = 0; int b_e;
        reiniciar();
        inicia(2'b01, 1'b0, stp, dur, leds);
        bus.configuracao = 2'b00;
        for (int r = 0; r <= LIM_DEMO; r++) rodada(r, (r < LIM_DEMO), -1, falhas);
        espera_estado(5'd13, 10);
        checks++;
        if (bus.db_estado !== 5'd13) begin failures++; $display("FAIL latch_demo: got %0d expected 13", bus.db_estado); end
        reiniciar();
        b_e = n_escreve;
        inicia(2'b00, 1'b0, stp, dur, leds);
        bus.configuracao = 2'b01;
        for (int r = 0; r <= LIM_DEMO; r++) rodada(r, 1'b1, -1, falhas);
        espera_estado(5'd3, 20);
        checks++;
        if (bus.db_estado !== 5'd3) begin failures++; $display("FAIL latch_normal: got %0d expected 3", bus.db_estado); end
        checks++;
        if (n_escreve - b_e != LIM_DEMO + 1) begin failures++; $display("FAIL latch_escreve: got %0d expected %0d", n_escreve - b_e, LIM_DEMO + 1); end
        checks++;
        if (falhas != 0) begin failures++; $display("FAIL latch_jogadas: got %0d bad plays expected 0", falhas); end
    endtask

    task automatic test_reset_meio();
        logic [4:0] stp; int dur; logic leds; int falhas = 0; bit ch, lo; int b_e, b_l;
        reiniciar();
        inicia(2'b01, 1'b0, stp, dur, leds);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.db_estado !== 5'd0 || bus.zeraE !== 1'b1) begin
            failures++; $display("FAIL reset_espera: got estado=%0d zeraE=%b expected estado=0 zeraE=1", bus.db_estado, bus.zeraE);
        end
        reset = 1'b0;
        tick();
        inicia(2'b01, 1'b0, stp, dur, leds);
        rodada(0, 1'b0, -1, falhas);
        faz_jogada(4'($urandom), ch, lo);
        checks++;
        if (bus.db_estado !== 5'd11 || !ch || !lo || falhas != 0) begin
            failures++; $display("FAIL reset_pre_escreve: got estado=%0d expected 11", bus.db_estado);
        end
        b_e = n_escreve; b_l = n_contal;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.escreve !== 1'b0 || bus.db_estado !== 5'd0) begin
            failures++; $display("FAIL reset_escreve: got escreve=%b estado=%0d expected escreve=0 estado=0", bus.escreve, bus.db_estado);
        end
        tick();
        tick();
        checks++;
        if (n_escreve != b_e || n_contal != b_l) begin
            failures++; $display("FAIL reset_glitch: got escreve+%0d contaL+%0d expected 0 0", n_escreve - b_e, n_contal - b_l);
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.jogar = 1'b0;
        bus.jogada = 1'b0;
        bus.configuracao = 2'b00;
        test_reset();
        test_vitoria_demo();
        test_erro();
        test_timeout();
        test_sem_timeout();
        test_corrida();
        test_config_latch();
        test_reset_meio();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
